// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: 2-bit direction counter
// encoding, the allocation state, and the saturating counter step.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;

    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_e'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup / prediction and execute training signals of the BTB.
interface branch_target_buffer_if #(
    parameter int PC_W = 12
);
    logic            lookup_valid;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/btb_tag_match.sv
// Tag equality check: per-bit XNOR, AND-reduced, qualified by the entry valid.
module btb_tag_match #(
    parameter int TAG_W = 8
) (
    input  logic             valid,
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [TAG_W-1:0] probe_tag,
    output logic             hit
);
    assign hit = valid & (&(~(stored_tag ^ probe_tag)));
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: 1-cycle registered prediction, trained by resolved branches.
// Define BTB_BYPASS_EN to forward a same-index update into the same-cycle lookup.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int IDX_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    branch_target_buffer_if.slave  bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];
    ctr_e               ctr_d    [ENTRIES];

    logic               pred_hit_q, pred_hit_d;
    logic               pred_taken_q, pred_taken_d;
    logic [PC_W-1:0]    pred_target_q, pred_target_d;

    logic [IDX_W-1:0]   upd_idx, lk_idx;
    logic [TAG_W-1:0]   upd_tag, lk_tag;
    logic               upd_hit, lk_hit;

    logic               upd_write;
    logic [TAG_W-1:0]   new_tag;
    logic [PC_W-1:0]    new_target;
    ctr_e               new_ctr;

    logic               lk_valid;
    logic [TAG_W-1:0]   lk_stored_tag;
    logic [PC_W-1:0]    lk_target;
    ctr_e               lk_ctr;

    assign upd_idx = bus.upd_pc[IDX_W-1:0];
    assign upd_tag = bus.upd_pc[PC_W-1:IDX_W];
    assign lk_idx  = bus.lookup_pc[IDX_W-1:0];
    assign lk_tag  = bus.lookup_pc[PC_W-1:IDX_W];

    btb_tag_match #(.TAG_W(TAG_W)) u_upd_match (
        .valid      (valid_q[upd_idx]),
        .stored_tag (tag_q[upd_idx]),
        .probe_tag  (upd_tag),
        .hit        (upd_hit)
    );

    btb_tag_match #(.TAG_W(TAG_W)) u_lk_match (
        .valid      (lk_valid),
        .stored_tag (lk_stored_tag),
        .probe_tag  (lk_tag),
        .hit        (lk_hit)
    );

    // Training: hits step the counter, taken misses (re)allocate at WT.
    always_comb begin
        upd_write  = 1'b0;
        new_tag    = upd_tag;
        new_target = target_q[upd_idx];
        new_ctr    = ctr_q[upd_idx];
        if (bus.upd_valid) begin
            if (upd_hit) begin
                upd_write = 1'b1;
                new_ctr   = ctr_step(ctr_q[upd_idx], bus.upd_taken);
                if (bus.upd_taken) begin
                    new_target = bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                upd_write  = 1'b1;
                new_target = bus.upd_target;
                new_ctr    = CTR_ALLOC;
            end
        end
    end

    always_comb begin
        lk_valid      = valid_q[lk_idx];
        lk_stored_tag = tag_q[lk_idx];
        lk_target     = target_q[lk_idx];
        lk_ctr        = ctr_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (upd_write && (upd_idx == lk_idx)) begin
            lk_valid      = 1'b1;
            lk_stored_tag = new_tag;
            lk_target     = new_target;
            lk_ctr        = new_ctr;
        end
`endif
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_write) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = new_tag;
            target_d[upd_idx] = new_target;
            ctr_d[upd_idx]    = new_ctr;
        end

        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (bus.lookup_valid) begin
            pred_hit_d    = lk_hit;
            pred_taken_d  = lk_hit & lk_ctr[1];
            pred_target_d = lk_hit ? lk_target : '0;
        end
    end

    // Entry payload arrays are left unreset; valid bits gate them.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q       <= '0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;

endmodule
